ps2_receiver: RTL
=================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter FILTER_CYCLES, default 8, consecutive equal samples needed to accept a ps2_clock level change.
REQ-003 Parameter TIMEOUT_CYCLES, default 5000 (100 us at 50 MHz), maximum filtered-clock-high time inside a frame before the frame is aborted.
REQ-004 clock  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ps2_clock  input  1  raw PS/2 clock from connector; asynchronous to clock.
REQ-007 ps2_data  input  1  raw PS/2 data from connector; asynchronous to clock.
REQ-008 ps2_code  output  8  last correctly received scan code byte.
REQ-009 ps2_code_new  output  1  one-cycle strobe: ps2_code updated this cycle.
REQ-010 ps2_error  output  1  one-cycle strobe: frame rejected (parity, stop bit or timeout).

Function
REQ-011 ps2_clock and ps2_data SHALL each pass through a two-flop synchroniser before any other use.
REQ-012 Filtered clock SHALL change level only after FILTER_CYCLES consecutive synchronised samples of the new level; shorter pulses SHALL be ignored.
REQ-013 A falling edge of the filtered clock SHALL sample the synchronised data in the same cycle as the edge is detected.
REQ-014 Frame: 11 bits -- start (0), 8 data LSB first, odd parity, stop (1).
REQ-015 States: IDLE, DATA, PARITY, STOP; edge in IDLE with data 0 -> DATA (bit count 0); edge in IDLE with data 1 -> stay IDLE, no strobe.
REQ-016 DATA: shift sampled bit into bit (count) of shift register; after 8th bit -> PARITY.
REQ-017 PARITY: store sampled bit -> STOP.
REQ-018 STOP: if stop bit 1 and XOR of 8 data bits and parity bit equals 1, load ps2_code and pulse ps2_code_new; else pulse ps2_error; both cases -> IDLE.
REQ-019 ps2_code_new SHALL rise on the clock cycle after the stop-bit falling edge is detected (latency 1 cycle from edge detect); ps2_code valid in that cycle and held until next good frame.
REQ-020 ps2_code_new and ps2_error SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-021 Timeout counter SHALL run in any non-IDLE state while filtered clock is high, clear on every filtered falling edge; reaching TIMEOUT_CYCLES -> pulse ps2_error, discard partial frame, -> IDLE.
REQ-022 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and saturate, never wrap.
REQ-023 Consecutive frames with no idle gap SHALL both be received (no dead cycles required beyond filtering).
REQ-024 A bad frame SHALL leave ps2_code unchanged.

Reset
REQ-025 On reset: state IDLE, ps2_code 8'h00, ps2_code_new 0, ps2_error 0, shift register, bit count and timeout counter 0, synchronisers and filtered clock 1 (idle bus level).
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no strobe; the next start bit after release begins a fresh frame.

Structure
REQ-027 Package ps2_types SHALL hold the receiver state enum and frame constants (data bits 8, frame bits 11); no other package dependency.
REQ-028 One sub-module, ps2_sync_filter (synchroniser + FILTER_CYCLES filter + falling-edge strobe), instantiated for ps2_clock; data uses synchroniser only.

Verification
REQ-029 Frame 0x1D, parity 1, stop 1, 12.5 kHz bus clock -> ps2_code=8'h1D, one-cycle ps2_code_new, ps2_error 0.
REQ-030 Back-to-back frames 0xE0 (parity 0) then 0x75 (parity 0) -> two strobes, codes 8'hE0 then 8'h75 in order.
REQ-031 Frame 0xF0 with parity 0 (wrong) -> one-cycle ps2_error, no ps2_code_new, ps2_code keeps previous value.
REQ-032 Five bits of a frame then ps2_clock held high > TIMEOUT_CYCLES -> ps2_error once; following full 0x1C frame (parity 0) -> ps2_code=8'h1C.
REQ-033 3-cycle low glitch on ps2_clock in IDLE and mid-frame -> ignored; frame 0x23 (parity 0) still decodes correctly.
REQ-034 Reset pulsed after 4 bits of frame 0x29 -> no strobes; next full 0x29 frame (parity 0) -> ps2_code=8'h29, one ps2_code_new.

Source files
------------

// File: rtl/ps2_types.sv
// Receiver state encoding and PS/2 frame geometry shared by the receiver and its bench.
package ps2_types;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus persistence filter and falling-edge strobe for one raw PS/2 line.
// filt_o follows raw_i 2 + FILTER_CYCLES cycles late; fall_o is high in the first cycle filt_o reads low.
module ps2_sync_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic             meta_q;
  logic             sync_q;
  logic             filt_q, filt_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        filt_d = sync_q;
        fall_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver; code/error strobes one cycle after the stop-bit edge is detected.
// No backpressure: each frame yields exactly one ps2_code_new or one ps2_error pulse.
module ps2_receiver
  import ps2_types::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 10_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] ps2_code,
  output logic       ps2_code_new,
  output logic       ps2_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic                 clk_filt;
  logic                 clk_fall;
  logic                 data_meta_q;
  logic                 data_sync_q;

  rx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [7:0]           code_q, code_d;
  logic                 code_new_q, code_new_d;
  logic                 error_q, error_d;

  ps2_sync_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (ps2_clock),
    .filt_o (clk_filt),
    .fall_o (clk_fall)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    parity_d   = parity_q;
    code_d     = code_q;
    code_new_d = 1'b0;
    error_d    = 1'b0;

    // Measures how long the bus clock has sat high inside a frame; saturates at the limit.
    if (state_q == ST_IDLE || clk_fall) begin
      to_cnt_d = '0;
    end else if (clk_filt && to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (clk_fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d[bit_cnt_q] = data_sync_q;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          parity_d = data_sync_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (data_sync_q && ((^shift_q) ^ parity_q)) begin
            code_d     = shift_q;
            code_new_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
      error_d   = 1'b1;
      state_d   = ST_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      code_q      <= 8'h00;
      code_new_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      code_q      <= code_d;
      code_new_q  <= code_new_d;
      error_q     <= error_d;
    end
  end

  assign ps2_code     = code_q;
  assign ps2_code_new = code_new_q;
  assign ps2_error    = error_q;

endmodule
